lfsr_gen: RTL and testbench

LFSR_GEN -- requirements
Module: lfsr_gen

---
 rtl/lfsr_pkg.sv | 56 +++++
 rtl/lfsr_fb.sv | 16 +
 rtl/lfsr_gen.sv | 122 ++++++++++++
 tb/tb_lfsr_gen.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: FSM encoding and per-width default feedback masks.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package lfsr_pkg;

    localparam int unsigned LFSR_MIN_WIDTH = 2;
    localparam int unsigned LFSR_MAX_WIDTH = 32;

    // IDLE: no valid output yet; RUN: q carries a sequence value.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } lfsr_state_e;

    // Maximal-length feedback masks for a left-shifting Fibonacci LFSR whose
    // feedback enters bit 0; mask bit (k-1) selects the x^k polynomial term.
    function automatic logic [31:0] default_taps(input int unsigned width);
        logic [31:0] taps;
        case (width)
            2:       taps = 32'h0000_0003;
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0004_0023;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_fb.sv
// LFSR feedback bit: XOR reduction of the state bits selected by TAPS.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is used.
module lfsr_fb
    import lfsr_pkg::*;
#(
    parameter int unsigned         WIDTH = 4,
    parameter logic [WIDTH-1:0]    TAPS  = WIDTH'(default_taps(WIDTH))
) (
    input  logic [WIDTH-1:0] state_i,
    output logic             fb_o
);

    assign fb_o = ^(state_i & TAPS);

endmodule

// File: rtl/lfsr_gen.sv
// Free-running Fibonacci LFSR with load, lock-up recovery, wrap detection and advance counter.
// Latency: one cycle from an accepted advance or load to the new q.
// Backpressure: advances only on en & out_valid & out_ready; otherwise q/count/out_valid hold.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned         WIDTH        = 4,
    parameter logic [WIDTH-1:0]    TAPS         = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0]    SEED_DEFAULT = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             en,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             lockup,
    output logic [WIDTH-1:0] count
);

    lfsr_state_e      fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q, lockup_d;

    logic             fb;
    logic [WIDTH-1:0] shift_nxt;
    logic             advance;

    lfsr_fb #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_fb (
        .state_i (state_q),
        .fb_o    (fb)
    );

    assign shift_nxt = {state_q[WIDTH-2:0], fb};
    assign advance   = (fsm_q == ST_RUN) && en && out_valid_q && out_ready;

    // Next-state selection: load beats everything, IDLE start-up, then a handshaken advance.
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        start_d     = start_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        wrap_d      = 1'b0;
        lockup_d    = 1'b0;

        if (load) begin
            // A zero seed would freeze the register, so it is replaced like a lock-up.
            if (seed == '0) begin
                state_d  = SEED_DEFAULT;
                start_d  = SEED_DEFAULT;
                lockup_d = 1'b1;
            end else begin
                state_d  = seed;
                start_d  = seed;
            end
            count_d     = '0;
            fsm_d       = ST_RUN;
            out_valid_d = 1'b1;
        end else if (fsm_q == ST_IDLE) begin
            if (en) begin
                state_d     = SEED_DEFAULT;
                start_d     = SEED_DEFAULT;
                count_d     = '0;
                fsm_d       = ST_RUN;
                out_valid_d = 1'b1;
            end
        end else if (advance) begin
            if (shift_nxt == '0) begin
                // Recovery takes precedence: the substituted seed does not count as a wrap.
                state_d  = SEED_DEFAULT;
                lockup_d = 1'b1;
                count_d  = '0;
            end else if (shift_nxt == start_q) begin
                state_d  = shift_nxt;
                wrap_d   = 1'b1;
                count_d  = '0;
            end else begin
                state_d  = shift_nxt;
                count_d  = count_q + WIDTH'(1);
            end
        end
    end

    // All generator state and registered outputs; reset forces the idle seed state at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q       <= ST_IDLE;
            state_q     <= SEED_DEFAULT;
            start_q     <= SEED_DEFAULT;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            lockup_q    <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            start_q     <= start_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            wrap_q      <= wrap_d;
            lockup_q    <= lockup_d;
        end
    end

    assign q         = state_q;
    assign out_valid = out_valid_q;
    assign wrap      = wrap_q;
    assign lockup    = lockup_q;
    assign count     = count_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: directed vectors plus randomized load/en/ready traffic.
// Latency: expected values are queued one clock ahead of the cycle they describe.
// Backpressure: out_ready is toggled randomly; holds are checked through the scoreboard.
module tb_lfsr_gen;

    localparam int W      = 4;
    localparam int MOD    = 16;
    localparam int SEED   = 1;
    localparam int TAPS_A = 12;  // x^4 + x^3 + 1

    logic         clk;
    logic         rst;
    logic         load, en, out_ready;
    logic [W-1:0] seed;
    logic         out_valid, wrap, lockup;
    logic [W-1:0] q, count;

    logic         d2_load, d2_en, d2_out_ready;
    logic [W-1:0] d2_seed;
    logic         d2_out_valid, d2_wrap, d2_lockup;
    logic [W-1:0] d2_q, d2_count;

    lfsr_gen u_dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .seed      (seed),
        .en        (en),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .q         (q),
        .wrap      (wrap),
        .lockup    (lockup),
        .count     (count)
    );

    lfsr_gen #(
        .WIDTH (4),
        .TAPS  (4'b0100)
    ) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .load      (d2_load),
        .seed      (d2_seed),
        .en        (d2_en),
        .out_ready (d2_out_ready),
        .out_valid (d2_out_valid),
        .q         (d2_q),
        .wrap      (d2_wrap),
        .lockup    (d2_lockup),
        .count     (d2_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int q;
        int valid;
        int wrap;
        int lock;
        int count;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_on = 1'b0;

    // Reference model state (plain integers)
    int m_run, m_state, m_start, m_count, m_wrap, m_lock;

    int seq_tbl[15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int next_val(input int s, input int taps);
        return ((s * 2) + ($countones(s & taps) % 2)) % MOD;
    endfunction

    task automatic model_reset();
        m_run   = 0;
        m_state = SEED;
        m_start = SEED;
        m_count = 0;
        m_wrap  = 0;
        m_lock  = 0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.q     = m_state;
        e.valid = m_run;
        e.wrap  = m_wrap;
        e.lock  = m_lock;
        e.count = m_count;
        exp_q.push_back(e);
    endtask

    // Behaviour of one clock edge given the inputs presented before it.
    task automatic model_edge(input int ld, input int sd, input int e, input int rdy);
        int nxt;
        m_wrap = 0;
        m_lock = 0;
        if (ld != 0) begin
            if (sd == 0) begin
                m_state = SEED;
                m_lock  = 1;
            end else begin
                m_state = sd;
            end
            m_start = m_state;
            m_count = 0;
            m_run   = 1;
        end else if (m_run == 0) begin
            if (e != 0) begin
                m_run   = 1;
                m_state = SEED;
                m_start = SEED;
                m_count = 0;
            end
        end else if (e != 0 && rdy != 0) begin
            nxt = next_val(m_state, TAPS_A);
            if (nxt == 0) begin
                m_state = SEED;
                m_lock  = 1;
                m_count = 0;
            end else if (nxt == m_start) begin
                m_state = nxt;
                m_wrap  = 1;
                m_count = 0;
            end else begin
                m_state = nxt;
                m_count = (m_count + 1) % MOD;
            end
        end
    endtask

    // Drive one cycle of stimulus, queue the expected post-edge outputs, move past the edge.
    task automatic step(input int ld, input int sd, input int e, input int rdy);
        load      = (ld != 0);
        seed      = 4'(sd);
        en        = (e != 0);
        out_ready = (rdy != 0);
        model_edge(ld, sd, e, rdy);
        push_exp();
        @(posedge clk);
        #1;
    endtask

    // Pull reset low between edges and confirm outputs clear before the next edge.
    task automatic async_reset();
        #2;
        rst       = 1'b0;
        load      = 1'b0;
        en        = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        chk("arst_q", q, SEED);
        chk("arst_valid", out_valid, 0);
        chk("arst_count", count, 0);
        push_exp();
        push_exp();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: compares the DUT outputs against the queued expectation every falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: no expected entry for cycle at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_q", q, e.q);
                    chk("sb_valid", out_valid, e.valid);
                    chk("sb_wrap", wrap, e.wrap);
                    chk("sb_lockup", lockup, e.lock);
                    chk("sb_count", count, e.count);
                end
            end
        end
    end

    initial begin
        int guard;
        rst          = 1'b1;
        load         = 1'b0;
        seed         = '0;
        en           = 1'b0;
        out_ready    = 1'b0;
        d2_load      = 1'b0;
        d2_seed      = '0;
        d2_en        = 1'b0;
        d2_out_ready = 1'b0;
        model_reset();

        #1 rst = 1'b0;
        #1;
        chk("rst_q", q, SEED);
        chk("rst_valid", out_valid, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_lockup", lockup, 0);
        chk("rst_count", count, 0);
        chk("rst_d2_q", d2_q, SEED);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        push_exp();
        mon_on = 1'b1;

        // Nothing happens after reset until load or en
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("idle_valid", out_valid, 0);
        chk("idle_q", q, SEED);

        // en alone starts the generator from the default seed
        step(0, 0, 1, 0);
        chk("start_valid", out_valid, 1);
        chk("start_q", q, SEED);

        // Sparse taps: 1000 shifts to all zeros and is recovered
        d2_load      = 1'b1;
        d2_seed      = 4'b1000;
        d2_out_ready = 1'b1;
        step(0, 0, 0, 0);
        chk("d2_load_q", d2_q, 8);
        chk("d2_load_valid", d2_out_valid, 1);
        d2_load = 1'b0;
        d2_en   = 1'b1;
        step(0, 0, 0, 0);
        chk("d2_lock_q", d2_q, 1);
        chk("d2_lock_pulse", d2_lockup, 1);
        chk("d2_lock_count", d2_count, 0);
        d2_en = 1'b0;
        step(0, 0, 0, 0);
        chk("d2_lock_once", d2_lockup, 0);
        chk("d2_hold_q", d2_q, 1);

        // Full period from seed 0001 with wrap on the 15th advance
        step(1, 1, 1, 1);
        chk("seq_0", q, seq_tbl[0]);
        chk("seq_0_count", count, 0);
        for (int i = 1; i < 15; i++) begin
            step(0, 0, 1, 1);
            chk($sformatf("seq_%0d", i), q, seq_tbl[i]);
            chk($sformatf("seq_%0d_wrap", i), wrap, 0);
        end
        step(0, 0, 1, 1);
        chk("wrap_q", q, 1);
        chk("wrap_pulse", wrap, 1);
        chk("wrap_count", count, 0);
        step(0, 0, 1, 1);
        chk("wrap_once", wrap, 0);
        chk("post_wrap_q", q, 2);
        step(0, 0, 1, 1);
        chk("at_0100", q, 4);

        // Consumer stall holds everything
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0);
            chk("stall_q", q, 4);
            chk("stall_count", count, 2);
            chk("stall_valid", out_valid, 1);
        end
        step(0, 0, 1, 1);
        chk("resume_q", q, 9);
        chk("resume_count", count, 3);

        // Zero seed is replaced by the default seed
        step(1, 0, 1, 1);
        chk("zseed_q", q, 1);
        chk("zseed_lockup", lockup, 1);
        chk("zseed_count", count, 0);
        step(0, 0, 0, 1);
        chk("zseed_lockup_once", lockup, 0);

        // Load wins over a simultaneous advance, then reset mid-sequence
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(1, 6, 1, 1);
        chk("ldpri_q", q, 6);
        chk("ldpri_count", count, 0);
        chk("ldpri_wrap", wrap, 0);
        step(0, 0, 1, 1);
        chk("ldpri_adv_q", q, 13);
        async_reset();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset();
            end else begin
                step(int'($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3) != 0));
            end
        end

        load      = 1'b0;
        en        = 1'b0;
        out_ready = 1'b0;
        guard     = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
